// File: rtl/weight_cache_rx_pkg.sv
// Shared constants for the weight cache receive path: FSM state codes and an address-width helper.
package weight_cache_rx_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 2'd1;
    localparam logic [STATE_W-1:0] ST_READY = 2'd2;

    // Bits needed to address n words; never less than one.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_ram.sv
// Simple dual-port RAM: one write port, one registered read port with clock enable.
module weight_ram
    import weight_cache_rx_pkg::*;
#(
    parameter int unsigned mem_size   = 288,
    parameter int unsigned data_width = 16
) (
    input  logic                           clk,
    input  logic [addr_w(mem_size)-1:0]    address0,
    input  logic                           ce0,
    output logic [data_width-1:0]          q0,
    input  logic [addr_w(mem_size)-1:0]    address1,
    input  logic                           we1,
    input  logic [data_width-1:0]          d1
);

    logic [data_width-1:0] mem [mem_size];

    always_ff @(posedge clk) begin
        if (we1) mem[address1] <= d1;
        if (ce0) q0 <= mem[address0];
    end

endmodule

// File: rtl/weight_cache_rx.sv
// Pops one coefficient set from the weight stream FIFO into local RAM and serves it
// to the conv datapath through a ROM-style port until the set is released.
module weight_cache_rx
    import weight_cache_rx_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned KERN_SIZE   = 288,
    parameter bit          AUTO_LOAD   = 1'b0
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [COEFF_WIDTH-1:0]         input_V_dout,
    input  logic                           input_V_empty_n,
    output logic                           input_V_read,
    input  logic                           load_start,
    input  logic                           release_set,
    output logic                           load_busy,
    output logic                           weights_ready,
    input  logic [addr_w(KERN_SIZE)-1:0]   weight_address0,
    input  logic                           weight_ce0,
    output logic [COEFF_WIDTH-1:0]         weight_q0
);

    localparam int unsigned        AW        = addr_w(KERN_SIZE);
    localparam logic [AW-1:0]      LAST_ADDR = AW'(KERN_SIZE - 1);
    localparam logic [STATE_W-1:0] RST_STATE = AUTO_LOAD ? ST_LOAD : ST_IDLE;

    logic [STATE_W-1:0]     state;
    logic [STATE_W-1:0]     next_state;
    logic [AW-1:0]          waddr;
    logic                   last_pop;
    logic                   addr_oor;
    logic                   zero_q;
    logic [AW-1:0]          ram_raddr;
    logic [COEFF_WIDTH-1:0] ram_q;

    assign last_pop = input_V_read && (waddr == LAST_ADDR);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= RST_STATE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (load_start && !AUTO_LOAD) next_state = ST_LOAD;
            ST_LOAD:  if (last_pop) next_state = ST_READY;
            ST_READY: if (release_set) next_state = AUTO_LOAD ? ST_LOAD : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Gated by reset so a reset mid-load stops popping in the same cycle.
    always_comb begin
        input_V_read  = 1'b0;
        load_busy     = 1'b0;
        weights_ready = 1'b0;
        if (!ap_rst) begin
            input_V_read  = (state == ST_LOAD) && input_V_empty_n;
            load_busy     = (state == ST_LOAD);
            weights_ready = (state == ST_READY);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst)            waddr <= '0;
        else if (input_V_read) waddr <= last_pop ? '0 : waddr + AW'(1);
    end

    // Out-of-range reads return zero; the RAM only ever sees a legal address.
    assign addr_oor  = 32'(weight_address0) >= KERN_SIZE;
    assign ram_raddr = addr_oor ? '0 : weight_address0;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)          zero_q <= 1'b1;
        else if (weight_ce0) zero_q <= addr_oor;
    end

    assign weight_q0 = zero_q ? '0 : ram_q;

    weight_ram #(
        .mem_size   (KERN_SIZE),
        .data_width (COEFF_WIDTH)
    ) u_ram (
        .clk      (ap_clk),
        .address0 (ram_raddr),
        .ce0      (weight_ce0),
        .q0       (ram_q),
        .address1 (waddr),
        .we1      (input_V_read),
        .d1       (input_V_dout)
    );

endmodule

// File: tb/tb_weight_cache_rx.sv
// Bench for weight_cache_rx: directed table, randomized traffic against a set-level model,
// reset mid-load, and an AUTO_LOAD instance.
module tb_weight_cache_rx;

    localparam int unsigned KS_A = 5;
    localparam int unsigned KS_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: KERN_SIZE=5, AUTO_LOAD=0
    logic        rst_a, empty_a, read_a, ls_a, rel_a, busy_a, rdy_a, ce_a;
    logic [15:0] dout_a, q_a;
    logic [2:0]  addr_a;

    // DUT B: KERN_SIZE=4, AUTO_LOAD=1
    logic        rst_b, empty_b, read_b, ls_b, rel_b, busy_b, rdy_b, ce_b;
    logic [15:0] dout_b, q_b;
    logic [1:0]  addr_b;

    weight_cache_rx #(.COEFF_WIDTH(16), .KERN_SIZE(KS_A), .AUTO_LOAD(1'b0)) dut_a (
        .ap_clk(clk), .ap_rst(rst_a), .input_V_dout(dout_a), .input_V_empty_n(empty_a),
        .input_V_read(read_a), .load_start(ls_a), .release_set(rel_a), .load_busy(busy_a),
        .weights_ready(rdy_a), .weight_address0(addr_a), .weight_ce0(ce_a), .weight_q0(q_a)
    );

    weight_cache_rx #(.COEFF_WIDTH(16), .KERN_SIZE(KS_B), .AUTO_LOAD(1'b1)) dut_b (
        .ap_clk(clk), .ap_rst(rst_b), .input_V_dout(dout_b), .input_V_empty_n(empty_b),
        .input_V_read(read_b), .load_start(ls_b), .release_set(rel_b), .load_busy(busy_b),
        .weights_ready(rdy_b), .weight_address0(addr_b), .weight_ce0(ce_b), .weight_q0(q_b)
    );

    // Set-level reference model for DUT A
    logic [15:0] fifo_a[$];
    logic [15:0] m_mem [KS_A];
    bit          m_loading, m_ready;
    int          m_cnt;
    logic [15:0] m_q;

    typedef struct {
        bit          gate, ls, rel, ce;
        int          addr;
        bit          e_read, e_busy, e_rdy;
        logic [15:0] e_q;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of DUT A: drive at negedge, check pop strobe, advance model, check registered outputs.
    task automatic cyc_a(input bit gate, input bit ls, input bit rel, input bit ce, input int addr,
                         output bit o_read, output bit o_busy, output bit o_rdy, output logic [15:0] o_q);
        bit er;
        @(negedge clk);
        empty_a = gate && (fifo_a.size() > 0);
        dout_a  = (fifo_a.size() > 0) ? fifo_a[0] : 16'h0;
        ls_a = ls; rel_a = rel; ce_a = ce; addr_a = 3'(addr);
        #1;
        er = m_loading && empty_a;
        chk("read_strobe", 32'(read_a), 32'(er));
        o_read = read_a;
        @(posedge clk);
        if (ce) m_q = (addr < int'(KS_A)) ? m_mem[addr] : 16'h0;
        if (m_loading) begin
            if (er) begin
                m_mem[m_cnt] = fifo_a.pop_front();
                m_cnt++;
                if (m_cnt == int'(KS_A)) begin
                    m_cnt = 0; m_loading = 0; m_ready = 1;
                end
            end
        end else if (m_ready) begin
            if (rel) m_ready = 0;
        end else if (ls) begin
            m_loading = 1;
        end
        #1;
        chk("load_busy", 32'(busy_a), 32'(m_loading));
        chk("weights_ready", 32'(rdy_a), 32'(m_ready));
        chk("weight_q0", 32'(q_a), 32'(m_q));
        o_busy = busy_a; o_rdy = rdy_a; o_q = q_a;
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1; empty_a = 0; ls_a = 0; rel_a = 0; ce_a = 0; addr_a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_ready", 32'(rdy_a), 0);
        chk("rst_q", 32'(q_a), 0);
        chk("rst_read", 32'(read_a), 0);
        @(negedge clk);
        rst_a = 0;
        m_loading = 0; m_ready = 0; m_cnt = 0; m_q = '0;
        fifo_a.delete();
    endtask

    bit          r_read, r_busy, r_rdy;
    logic [15:0] r_q;
    int          b_val;

    initial begin
        rst_a = 1; empty_a = 0; dout_a = '0; ls_a = 0; rel_a = 0; ce_a = 0; addr_a = '0;
        rst_b = 1; empty_b = 0; dout_b = '0; ls_b = 0; rel_b = 0; ce_b = 0; addr_b = '0;

        // Directed bubbles / readback / range / release+load_start; FIFO preloaded 1..10
        tbl[0]  = '{1,1,0,0,0, 0,1,0,16'd0};
        tbl[1]  = '{1,0,0,0,0, 1,1,0,16'd0};
        tbl[2]  = '{0,0,0,0,0, 0,1,0,16'd0};
        tbl[3]  = '{1,0,0,0,0, 1,1,0,16'd0};
        tbl[4]  = '{1,0,0,0,0, 1,1,0,16'd0};
        tbl[5]  = '{0,0,0,0,0, 0,1,0,16'd0};
        tbl[6]  = '{1,0,0,0,0, 1,1,0,16'd0};
        tbl[7]  = '{1,0,0,0,0, 1,0,1,16'd0};
        tbl[8]  = '{1,0,0,1,0, 0,0,1,16'd1};
        tbl[9]  = '{1,0,0,1,4, 0,0,1,16'd5};
        tbl[10] = '{1,0,0,1,6, 0,0,1,16'd0};
        tbl[11] = '{1,0,0,0,2, 0,0,1,16'd0};
        tbl[12] = '{1,0,0,1,3, 0,0,1,16'd4};
        tbl[13] = '{1,1,1,1,1, 0,0,0,16'd2};
        tbl[14] = '{1,0,0,0,0, 0,0,0,16'd2};

        reset_a();
        for (int i = 1; i <= 10; i++) fifo_a.push_back(16'(i));
        for (int i = 0; i < 15; i++) begin
            cyc_a(tbl[i].gate, tbl[i].ls, tbl[i].rel, tbl[i].ce, tbl[i].addr, r_read, r_busy, r_rdy, r_q);
            chk($sformatf("tbl%0d_read", i), 32'(r_read), 32'(tbl[i].e_read));
            chk($sformatf("tbl%0d_busy", i), 32'(r_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_ready", i), 32'(r_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_q", i), 32'(r_q), 32'(tbl[i].e_q));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            while (fifo_a.size() < 3) fifo_a.push_back(16'($urandom));
            cyc_a(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), r_read, r_busy, r_rdy, r_q);
        end

        // Reset after 2 of 5 words, then a clean load of 9..13
        reset_a();
        for (int i = 9; i <= 13; i++) fifo_a.push_back(16'(i));
        cyc_a(1, 1, 0, 0, 0, r_read, r_busy, r_rdy, r_q);
        repeat (2) cyc_a(1, 0, 0, 0, 0, r_read, r_busy, r_rdy, r_q);
        @(negedge clk);
        rst_a = 1; empty_a = 1; dout_a = fifo_a[0];
        #1;
        chk("midload_rst_read_drop", 32'(read_a), 0);
        chk("midload_rst_busy_drop", 32'(busy_a), 0);
        @(posedge clk); #1;
        chk("midload_rst_ready", 32'(rdy_a), 0);
        chk("midload_rst_read", 32'(read_a), 0);
        reset_a();
        for (int i = 9; i <= 13; i++) fifo_a.push_back(16'(i));
        cyc_a(1, 1, 0, 0, 0, r_read, r_busy, r_rdy, r_q);
        for (int i = 0; i < 5; i++) cyc_a(1, 0, 0, 0, 0, r_read, r_busy, r_rdy, r_q);
        chk("reload_ready", 32'(r_rdy), 1);
        for (int i = 0; i < 5; i++) begin
            cyc_a(0, 0, 0, 1, i, r_read, r_busy, r_rdy, r_q);
            chk($sformatf("reload_q%0d", i), 32'(r_q), 32'(9 + i));
        end

        // AUTO_LOAD instance: loads straight out of reset, reloads on release
        @(negedge clk);
        empty_b = 1; dout_b = 16'd100;
        #1;
        chk("b_rst_read", 32'(read_b), 0);
        chk("b_rst_busy", 32'(busy_b), 0);
        @(negedge clk);
        rst_b = 0; b_val = 0; dout_b = 16'd100;
        #1;
        chk("b_auto_busy", 32'(busy_b), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b_pop%0d", k), 32'(read_b), 1);
            @(posedge clk);
            b_val++;
            @(negedge clk);
            dout_b = 16'(100 + b_val);
            #1;
        end
        chk("b_ready", 32'(rdy_b), 1);
        chk("b_busy_low", 32'(busy_b), 0);
        chk("b_no_read", 32'(read_b), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ce_b = 1; addr_b = 2'(i);
            @(posedge clk); #1;
            chk($sformatf("b_q%0d", i), 32'(q_b), 32'(100 + i));
        end
        @(negedge clk); ce_b = 0; rel_b = 1;
        @(posedge clk); #1;
        chk("b_release_busy", 32'(busy_b), 1);
        chk("b_release_ready", 32'(rdy_b), 0);
        @(negedge clk); rel_b = 0; dout_b = 16'(100 + b_val);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b_repop%0d", k), 32'(read_b), 1);
            @(posedge clk);
            b_val++;
            @(negedge clk);
            dout_b = 16'(100 + b_val);
            #1;
        end
        chk("b_ready2", 32'(rdy_b), 1);
        @(negedge clk); ce_b = 1; addr_b = 2'd2;
        @(posedge clk); #1;
        chk("b_q2_second_set", 32'(q_b), 106);
        @(negedge clk); addr_b = 2'd0;
        @(posedge clk); #1;
        chk("b_q0_second_set", 32'(q_b), 104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
